clk_divider_multi: RTL

- Parametrised, multi-channel programmable clock divider; successor to the fixed single-channel 1 Hz toggle divider.
- Each channel derives a slow enable-style clock or strobe from iClk, using a divisor loadable at runtime.
- Each channel has two modes: toggle (near-50% duty) or single-cycle pulse.
- Sits between the system clock and slow consumers (LED blink, seven-segment scan, debounce sampling). Outputs are logic signals in the iClk domain, not clock-tree drivers.

---
 rtl/clk_divider_multi.sv | 120 ++++++++++++
 1 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: per-channel toggle or pulse output,
// runtime-loadable divisor/mode, global phase-align strobe.

module clk_div_ch #(
  parameter int CNT_W        = 25,
  parameter int DEFAULT_DIV  = 62500,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic             clk_o,
  output logic             tick_o
);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic             DEF_MODE = (DEFAULT_MODE != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             evt;

  assign evt = (cnt_q == div_q);

  always_comb begin
    div_d  = div_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (load_i) begin
      div_d  = div_i;
      mode_d = mode_i;
    end
    // Sync, load and disable all share the same restart of counter and outputs.
    if (clr_i || load_i || !en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else begin
      cnt_d = evt ? '0 : cnt_q + CNT_W'(1);
      if (mode_q) begin
        clk_d  = evt;
        tick_d = evt;
      end else begin
        clk_d  = clk_q ^ evt;
        tick_d = evt & ~clk_q;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      mode_q <= DEF_MODE;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
endmodule

module clk_divider_multi #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 25,
  parameter int DEFAULT_DIV  = 62500,
  parameter int DEFAULT_MODE = 0,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [NUM_CH-1:0] iEn,
  input  logic              iSync,
  input  logic              iLoad,
  input  logic [CH_W-1:0]   iCh,
  input  logic [CNT_W-1:0]  iDiv,
  input  logic              iMode,
  output logic [NUM_CH-1:0] oClk,
  output logic [NUM_CH-1:0] oTick
);
  logic              load_ok;
  logic [NUM_CH-1:0] load_hit;

  // Out-of-range channel indices never reach any lane.
  assign load_ok = iLoad && (int'(iCh) < NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load_hit[c] = load_ok && (iCh == CH_W'(c));

    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(DEFAULT_MODE)
    ) u_ch (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .en_i  (iEn[c]),
      .clr_i (iSync),
      .load_i(load_hit[c]),
      .div_i (iDiv),
      .mode_i(iMode),
      .clk_o (oClk[c]),
      .tick_o(oTick[c])
    );
  end
endmodule
